// File: rtl/fixed_bcd_formatter.sv
`default_nettype none
// ============================================================================
// Module      : fixed_bcd_formatter
// Description : Sequential converter from signed Q17.14 fixed point to
//               sign-magnitude BCD (6 integer digits, 4 fractional digits).
//               The integer part is converted by double-dabble and the
//               fraction by repeated multiply-by-10.
//               Optional macro FMT_ROUND_EN: generate a 5th fractional digit
//               and round half up (in magnitude) into the displayed digits.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_bcd_formatter (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] value_in,
  input  logic        ovf_in,
  output logic        busy,
  output logic        done,
  output logic        sign,
  output logic [23:0] int_bcd,
  output logic [15:0] frac_bcd,
  output logic        ovf_out,
  output logic        dropped
);

`ifdef FMT_ROUND_EN
  localparam int         FRAC_DIGITS = 5;
`else
  localparam int         FRAC_DIGITS = 4;
`endif
  localparam int         FACC_W      = 4 * FRAC_DIGITS;
  localparam logic [4:0] INT_LAST    = 5'd17;
  localparam logic [4:0] FRAC_LAST   = 5'(FRAC_DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ABS   = 3'd1,
    S_INT   = 3'd2,
    S_FRAC  = 3'd3,
`ifdef FMT_ROUND_EN
    S_ROUND = 3'd4,
`endif
    S_OUT   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [31:0]         value_q, value_d;
  logic                ovf_lat_q, ovf_lat_d;
  logic                sign_work_q, sign_work_d;
  logic [17:0]         int_sr_q, int_sr_d;
  logic [13:0]         frac_q, frac_d;
  logic [23:0]         ibcd_q, ibcd_d;
  logic [FACC_W-1:0]   facc_q, facc_d;
  logic                sign_q, sign_d;
  logic [23:0]         int_bcd_q, int_bcd_d;
  logic [15:0]         frac_bcd_q, frac_bcd_d;
  logic                ovf_out_q, ovf_out_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                dropped_q, dropped_d;

  logic [31:0]         mag;
  logic [23:0]         dabble_adj;
  logic [17:0]         prod;

  // Add 3 to every BCD nibble that is 5 or more (double-dabble correction).
  function automatic logic [23:0] dabble_fix(input logic [23:0] bcd);
    logic [23:0] r;
    logic [3:0]  nib;
    r = bcd;
    for (int i = 0; i < 6; i++) begin
      nib = bcd[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      r[4*i +: 4] = nib;
    end
    return r;
  endfunction

`ifdef FMT_ROUND_EN
  // Increment a 10-digit BCD number, carry rippling through every digit.
  function automatic logic [39:0] bcd_inc(input logic [39:0] bcd);
    logic [39:0] r;
    logic        carry;
    logic [3:0]  nib;
    r     = bcd;
    carry = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nib = bcd[4*i +: 4];
      if (carry) begin
        if (nib == 4'd9) begin
          nib = 4'd0;
        end else begin
          nib   = nib + 4'd1;
          carry = 1'b0;
        end
      end
      r[4*i +: 4] = nib;
    end
    return r;
  endfunction
`endif

  // Datapath helpers: absolute value, dabble correction, fraction times ten.
  always_comb begin
    mag        = value_q[31] ? (~value_q + 32'd1) : value_q;
    dabble_adj = dabble_fix(ibcd_q);
    prod       = 18'(frac_q) * 18'd10;
  end

  // Next-state and datapath update for the conversion sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    value_d     = value_q;
    ovf_lat_d   = ovf_lat_q;
    sign_work_d = sign_work_q;
    int_sr_d    = int_sr_q;
    frac_d      = frac_q;
    ibcd_d      = ibcd_q;
    facc_d      = facc_q;
    sign_d      = sign_q;
    int_bcd_d   = int_bcd_q;
    frac_bcd_d  = frac_bcd_q;
    ovf_out_d   = ovf_out_q;
    done_d      = 1'b0;
    dropped_d   = dropped_q;

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          value_d   = value_in;
          ovf_lat_d = ovf_in;
          dropped_d = 1'b0;
          state_d   = S_ABS;
        end
      end
      S_ABS: begin
        // 0x80000000 negates to itself, which reads correctly as 2^31 unsigned.
        sign_work_d = value_q[31];
        int_sr_d    = mag[31:14];
        frac_d      = mag[13:0];
        ibcd_d      = 24'd0;
        facc_d      = '0;
        cnt_d       = 5'd0;
        state_d     = S_INT;
      end
      S_INT: begin
        ibcd_d   = (dabble_adj << 1) | {23'd0, int_sr_q[17]};
        int_sr_d = {int_sr_q[16:0], 1'b0};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == INT_LAST) begin
          cnt_d   = 5'd0;
          state_d = S_FRAC;
        end
      end
      S_FRAC: begin
        // The integer part of frac*10 is the next decimal digit.
        facc_d = {facc_q[FACC_W-5:0], prod[17:14]};
        frac_d = prod[13:0];
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == FRAC_LAST) begin
          cnt_d = 5'd0;
`ifdef FMT_ROUND_EN
          state_d = S_ROUND;
`else
          state_d = S_OUT;
`endif
        end
      end
`ifdef FMT_ROUND_EN
      S_ROUND: begin
        // Guard digit decides round half up across all ten displayed digits.
        if (facc_q[3:0] >= 4'd5) begin
          {ibcd_d, facc_d[FACC_W-1:4]} = bcd_inc({ibcd_q, facc_q[FACC_W-1:4]});
        end
        state_d = S_OUT;
      end
`endif
      S_OUT: begin
        sign_d     = sign_work_q;
        int_bcd_d  = ibcd_q;
        frac_bcd_d = facc_q[FACC_W-1 -: 16];
        ovf_out_d  = ovf_lat_q;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A request that cannot be accepted is flagged but otherwise ignored.
    if (valid_in && (state_q != S_IDLE)) begin
      dropped_d = 1'b1;
    end

    // Busy covers the whole conversion plus the done cycle.
    busy_d = (state_d != S_IDLE) || done_d;
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      value_q     <= 32'd0;
      ovf_lat_q   <= 1'b0;
      sign_work_q <= 1'b0;
      int_sr_q    <= 18'd0;
      frac_q      <= 14'd0;
      ibcd_q      <= 24'd0;
      facc_q      <= '0;
      sign_q      <= 1'b0;
      int_bcd_q   <= 24'd0;
      frac_bcd_q  <= 16'd0;
      ovf_out_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      value_q     <= value_d;
      ovf_lat_q   <= ovf_lat_d;
      sign_work_q <= sign_work_d;
      int_sr_q    <= int_sr_d;
      frac_q      <= frac_d;
      ibcd_q      <= ibcd_d;
      facc_q      <= facc_d;
      sign_q      <= sign_d;
      int_bcd_q   <= int_bcd_d;
      frac_bcd_q  <= frac_bcd_d;
      ovf_out_q   <= ovf_out_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      dropped_q   <= dropped_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sign     = sign_q;
  assign int_bcd  = int_bcd_q;
  assign frac_bcd = frac_bcd_q;
  assign ovf_out  = ovf_out_q;
  assign dropped  = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_bcd_formatter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fixed_bcd_formatter
// Description : Self-checking bench for fixed_bcd_formatter. Directed vector
//               table plus hand-written sequences for dropped requests,
//               back-to-back capture and mid-conversion reset.
//               Honours FMT_ROUND_EN for latency and rounded expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_bcd_formatter;

`ifdef FMT_ROUND_EN
  localparam int LAT = 26;
`else
  localparam int LAT = 24;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] value_in = 32'd0;
  logic        ovf_in = 1'b0;
  logic        busy, done, sign, ovf_out, dropped;
  logic [23:0] int_bcd;
  logic [15:0] frac_bcd;

  int n_cmp = 0;
  int n_fail = 0;

  fixed_bcd_formatter dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .value_in (value_in),
    .ovf_in   (ovf_in),
    .busy     (busy),
    .done     (done),
    .sign     (sign),
    .int_bcd  (int_bcd),
    .frac_bcd (frac_bcd),
    .ovf_out  (ovf_out),
    .dropped  (dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    logic        ovf;
    logic        s;
    logic [23:0] ib;
    logic [15:0] fb;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one request; returns #1 after the capture edge.
  task automatic start(input logic [31:0] v, input logic o);
    @(negedge clk);
    valid_in = 1'b1;
    value_in = v;
    ovf_in   = o;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  // Count edges until done is seen (bounded); returns #1 after that edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
  endtask

  int lat;
  int done_seen;

  initial begin
    vecs[0]  = '{32'h0000_4000, 1'b0, 1'b0, 24'h000001, 16'h0000};
    vecs[1]  = '{32'hFFFF_6000, 1'b0, 1'b1, 24'h000002, 16'h5000};
    vecs[2]  = '{32'h7FFF_FFFF, 1'b0, 1'b0, 24'h131071, 16'h9999};
    vecs[3]  = '{32'h8000_0000, 1'b0, 1'b1, 24'h131072, 16'h0000};
`ifdef FMT_ROUND_EN
    vecs[4]  = '{32'h0000_0001, 1'b0, 1'b0, 24'h000000, 16'h0001};
`else
    vecs[4]  = '{32'h0000_0001, 1'b0, 1'b0, 24'h000000, 16'h0000};
`endif
    vecs[5]  = '{32'h0000_1555, 1'b1, 1'b0, 24'h000000, 16'h3333};
    vecs[6]  = '{32'h0000_0000, 1'b0, 1'b0, 24'h000000, 16'h0000};
    vecs[7]  = '{32'hFFFF_C000, 1'b0, 1'b1, 24'h000001, 16'h0000};
    vecs[8]  = '{32'h0001_2000, 1'b0, 1'b0, 24'h000004, 16'h5000};
    vecs[9]  = '{32'h0019_0000, 1'b1, 1'b0, 24'h000100, 16'h0000};
    vecs[10] = '{32'hFFFF_F000, 1'b0, 1'b1, 24'h000000, 16'h2500};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_int",   32'(int_bcd), 32'd0);
    chk("rst_frac",  32'(frac_bcd), 32'd0);
    chk("rst_flags", {29'd0, sign, ovf_out, dropped}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      start(vecs[i].val, vecs[i].ovf);
      chk($sformatf("v%0d_busy_rise", i), 32'(busy), 32'd1);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT));
      chk($sformatf("v%0d_sign", i), 32'(sign), 32'(vecs[i].s));
      chk($sformatf("v%0d_int", i), 32'(int_bcd), 32'(vecs[i].ib));
      chk($sformatf("v%0d_frac", i), 32'(frac_bcd), 32'(vecs[i].fb));
      chk($sformatf("v%0d_ovf", i), 32'(ovf_out), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_fall", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_busy_fall", i), 32'(busy), 32'd0);
    end

    // Dropped request: second valid 5 cycles after capture is ignored
    start(32'h0000_1555, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    valid_in = 1'b1;
    value_in = 32'h0000_4000;
    ovf_in   = 1'b0;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    chk("drop_set", 32'(dropped), 32'd1);
    wait_done(lat);
    chk("drop_latency", 32'(lat + 5), 32'(LAT));
    chk("drop_int", 32'(int_bcd), 32'h000000);
    chk("drop_frac", 32'(frac_bcd), 32'h3333);
    chk("drop_ovf", 32'(ovf_out), 32'd1);
    chk("drop_sticky", 32'(dropped), 32'd1);
    @(posedge clk);
    #1;
    start(32'h0000_4000, 1'b0);
    chk("drop_clear", 32'(dropped), 32'd0);
    wait_done(lat);
    chk("drop_next_int", 32'(int_bcd), 32'h000001);

    // Back-to-back: request during the done cycle is accepted
    valid_in = 1'b1;
    value_in = 32'hFFFF_6000;
    ovf_in   = 1'b0;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done_fall", 32'(done), 32'd0);
    chk("b2b_not_dropped", 32'(dropped), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("b2b_hold_int", 32'(int_bcd), 32'h000001);
    chk("b2b_hold_sign", 32'(sign), 32'd0);
    wait_done(lat);
    chk("b2b_latency", 32'(lat + 10), 32'(LAT));
    chk("b2b_sign", 32'(sign), 32'd1);
    chk("b2b_int", 32'(int_bcd), 32'h000002);
    chk("b2b_frac", 32'(frac_bcd), 32'h5000);

    // Reset 10 cycles into a conversion, after dropped has been set again
    @(posedge clk);
    #1;
    start(32'h7FFF_FFFF, 1'b1);
    @(negedge clk);
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_int", 32'(int_bcd), 32'd0);
    chk("mrst_frac", 32'(frac_bcd), 32'd0);
    chk("mrst_flags", {29'd0, sign, ovf_out, dropped}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    chk("mrst_no_done", 32'(done_seen), 32'd0);
    start(32'h8000_0000, 1'b0);
    wait_done(lat);
    chk("post_rst_latency", 32'(lat), 32'(LAT));
    chk("post_rst_sign", 32'(sign), 32'd1);
    chk("post_rst_int", 32'(int_bcd), 32'h131072);
    chk("post_rst_frac", 32'(frac_bcd), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
